alarm_sequencer: RTL and testbench



---
 rtl/alarm_pkg.sv | 28 ++
 rtl/ms_tick_gen.sv | 24 ++
 rtl/alarm_sequencer.sv | 152 +++++++++++++++
 tb/tb_alarm_sequencer.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm sequencer: FSM encoding,
// alert level encoding and the critical level class.
package alarm_pkg;

    // FSM encoding, also exported on fsm_state for debug LEDs
    typedef enum logic [1:0] {
        FSM_IDLE   = 2'd0,
        FSM_WARN   = 2'd1,
        FSM_URGENT = 2'd2,
        FSM_SNOOZE = 2'd3
    } fsm_e;

    // alert_lvl encoding seen by led_matrix / beep
    typedef enum logic [1:0] {
        LVL_NONE    = 2'd0,
        LVL_WARN    = 2'd1,
        LVL_URGENT  = 2'd2,
        LVL_SNOOZED = 2'd3
    } alert_lvl_e;

    // Highest level class; bypasses the warn stage when enabled
    localparam logic [2:0] CRIT_STATE = 3'd7;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running prescaler producing a 1-cycle strobe every CLK_DIV clocks.
module ms_tick_gen #(
    parameter int CLK_DIV = 1000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] cnt;

    // Count 0..CLK_DIV-1 and wrap; never restarted by the FSM
    always_ff @(posedge clk) begin
        if (rst)              cnt <= '0;
        else if (cnt == LAST) cnt <= '0;
        else                  cnt <= cnt + 1'b1;
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/alarm_sequencer.sv
// Alert scheduler: turns the level class into beeper / blink enables with
// warn -> urgent escalation, acknowledge-with-snooze and auto clear.
// Optional macro CRITICAL_BYPASS_EN: level 7 forces URGENT from any state
// and masks acknowledges while it persists.
module alarm_sequencer
    import alarm_pkg::*;
#(
    parameter int         CLK_DIV      = 1000,
    parameter logic [2:0] ALARM_LEVEL  = 3'd4,
    parameter int         ESC_MS       = 3000,
    parameter int         SNOOZE_MS    = 5000,
    parameter int         BEEP_HALF_MS = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] state,
    input  logic       ack,
    output logic       beep_en,
    output logic       blink_en,
    output logic [1:0] alert_lvl,
    output logic [1:0] fsm_state
);

    localparam logic [1:0] IDLE   = FSM_IDLE;
    localparam logic [1:0] WARN   = FSM_WARN;
    localparam logic [1:0] URGENT = FSM_URGENT;
    localparam logic [1:0] SNOOZE = FSM_SNOOZE;

    localparam int MS_MAX = max2(ESC_MS, SNOOZE_MS);
    localparam int CW     = (MS_MAX > 1) ? $clog2(MS_MAX) : 1;
    localparam int PH_W   = (2 * BEEP_HALF_MS > 1) ? $clog2(2 * BEEP_HALF_MS) : 1;

    localparam logic [CW-1:0]   ESC_LAST = CW'(ESC_MS - 1);
    localparam logic [CW-1:0]   SNZ_LAST = CW'(SNOOZE_MS - 1);
    localparam logic [PH_W-1:0] PH_LAST  = PH_W'(2 * BEEP_HALF_MS - 1);
    localparam logic [PH_W-1:0] PH_HALF  = PH_W'(BEEP_HALF_MS);

    logic            tick;
    logic            ack_q;
    logic            ack_rise;
    logic            ack_eff;
    logic            alarm;
    logic [1:0]      fsm_q, fsm_d;
    logic [CW-1:0]   ms_cnt, ms_cnt_d;
    logic [PH_W-1:0] phase, phase_d;

    ms_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign ack_rise = ack & ~ack_q;
    assign alarm    = (state >= ALARM_LEVEL);

`ifdef CRITICAL_BYPASS_EN
    logic crit;
    assign crit    = (state == CRIT_STATE);
    assign ack_eff = ack_rise & ~crit;
`else
    assign ack_eff = ack_rise;
`endif

    // Next-state decision; clear beats ack, ack beats timer expiry
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            IDLE:    if (alarm) fsm_d = WARN;
            WARN: begin
                if (!alarm)                         fsm_d = IDLE;
                else if (ack_eff)                   fsm_d = SNOOZE;
                else if (tick && ms_cnt == ESC_LAST) fsm_d = URGENT;
            end
            URGENT: begin
                if (!alarm)       fsm_d = IDLE;
                else if (ack_eff) fsm_d = SNOOZE;
            end
            default: begin
                if (!alarm)                         fsm_d = IDLE;
                else if (tick && ms_cnt == SNZ_LAST) fsm_d = WARN;
            end
        endcase
`ifdef CRITICAL_BYPASS_EN
        if (crit) fsm_d = URGENT;
`endif
    end

    // ms counter restarts on any state change; beep phase restarts on WARN entry
    always_comb begin
        ms_cnt_d = ms_cnt;
        phase_d  = phase;
        if (fsm_d != fsm_q)
            ms_cnt_d = '0;
        else if (tick && (fsm_q == WARN || fsm_q == SNOOZE))
            ms_cnt_d = ms_cnt + 1'b1;

        if (fsm_d != WARN || fsm_q != WARN)
            phase_d = '0;
        else if (tick)
            phase_d = (phase == PH_LAST) ? '0 : phase + 1'b1;
    end

    // State, timers and ack edge history
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q  <= IDLE;
            ms_cnt <= '0;
            phase  <= '0;
            ack_q  <= 1'b1;  // a button held through reset is not an edge
        end else begin
            fsm_q  <= fsm_d;
            ms_cnt <= ms_cnt_d;
            phase  <= phase_d;
            ack_q  <= ack;
        end
    end

    // Registered outputs decoded from the state being entered
    always_ff @(posedge clk) begin
        if (rst) begin
            beep_en   <= 1'b0;
            blink_en  <= 1'b0;
            alert_lvl <= LVL_NONE;
        end else begin
            case (fsm_d)
                IDLE: begin
                    beep_en   <= 1'b0;
                    blink_en  <= 1'b0;
                    alert_lvl <= LVL_NONE;
                end
                WARN: begin
                    beep_en   <= (phase_d < PH_HALF);
                    blink_en  <= 1'b1;
                    alert_lvl <= LVL_WARN;
                end
                URGENT: begin
                    beep_en   <= 1'b1;
                    blink_en  <= 1'b1;
                    alert_lvl <= LVL_URGENT;
                end
                default: begin
                    beep_en   <= 1'b0;
                    blink_en  <= 1'b1;
                    alert_lvl <= LVL_SNOOZED;
                end
            endcase
        end
    end

    assign fsm_state = fsm_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed + random bench for alarm_sequencer against a time-since-entry model.
module tb_alarm_sequencer;

    localparam int CLK_DIV = 4;
    localparam int ESC     = 10;
    localparam int SNZ     = 8;
    localparam int BH      = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] state = 3'd0;
    logic       ack = 1'b0;
    logic       beep_en, blink_en;
    logic [1:0] alert_lvl, fsm_state;

    int n_cmp = 0;
    int n_err = 0;

    // Model: mode numbering follows the alert meaning (none/warn/urgent/snoozed)
    int m_mode = 0;
    int m_pre  = 0;
    int m_ms   = 0;    // whole ms ticks spent in the current mode
    bit m_ackq = 1'b1;
    logic       e_beep = 1'b0, e_blink = 1'b0;
    logic [1:0] e_lvl = 2'd0;

    alarm_sequencer #(
        .CLK_DIV(CLK_DIV), .ALARM_LEVEL(3'd4), .ESC_MS(ESC),
        .SNOOZE_MS(SNZ), .BEEP_HALF_MS(BH)
    ) dut (
        .clk(clk), .rst(rst), .state(state), .ack(ack),
        .beep_en(beep_en), .blink_en(blink_en),
        .alert_lvl(alert_lvl), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit tk, rise, alarm, crit;
        int nm;
        if (rst) begin
            m_mode = 0; m_pre = 0; m_ms = 0; m_ackq = 1'b1;
        end else begin
            tk     = (m_pre == CLK_DIV - 1);
            m_pre  = (m_pre + 1) % CLK_DIV;
            rise   = ack && !m_ackq;
            m_ackq = ack;
            alarm  = (state >= 4);
            crit   = (state == 7);
            nm     = m_mode;
            if (m_mode == 0) begin
                if (alarm) nm = 1;
            end else if (!alarm) nm = 0;
            else if (rise && m_mode != 3) nm = 3;
            else if (m_mode == 1 && tk && m_ms + 1 == ESC) nm = 2;
            else if (m_mode == 3 && tk && m_ms + 1 == SNZ) nm = 1;
`ifdef CRITICAL_BYPASS_EN
            if (crit) nm = 2;
`else
            if (crit) nm = nm;
`endif
            if (nm != m_mode) m_ms = 0;
            else if (tk && (m_mode == 1 || m_mode == 3)) m_ms++;
            m_mode = nm;
        end
        e_lvl   = 2'(m_mode);
        e_blink = (m_mode != 0);
        e_beep  = (m_mode == 2) || (m_mode == 1 && (m_ms % (2 * BH)) < BH);
    endtask

    // One clock: model follows the edge, outputs checked on the falling edge
    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("beep_en",   beep_en,   e_beep);
        chk("blink_en",  blink_en,  e_blink);
        chk("alert_lvl", alert_lvl, e_lvl);
        chk("fsm_state", fsm_state, e_lvl);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        bit found;
        @(negedge clk);
        // Reset, then quiet level
        rst = 1'b1; run(3);
        chk("reset_lvl", alert_lvl, 0);
        chk("reset_beep", beep_en, 0);
        rst = 1'b0; run(100);
        chk("idle_fsm", fsm_state, 0);

        // Enter WARN, escalate
        state = 3'd4; cyc();
        chk("warn_lvl", alert_lvl, 1);
        chk("warn_blink", blink_en, 1);
        chk("warn_beep_first", beep_en, 1);
        run(50);
        chk("urgent_lvl", alert_lvl, 2);
        chk("urgent_beep", beep_en, 1);

        // Ack from URGENT, snooze then back to WARN
        ack = 1'b1; cyc(); ack = 1'b0;
        chk("snooze_lvl", alert_lvl, 3);
        chk("snooze_beep", beep_en, 0);
        run(40);
        chk("resume_warn", alert_lvl, 1);

        // Clear, ack and expiry all on the same edge
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (m_mode == 1 && m_ms == ESC - 1 && m_pre == CLK_DIV - 1) found = 1'b1;
            else cyc();
        end
        chk("expiry_edge_found", found, 1);
        state = 3'd3; ack = 1'b1; cyc(); ack = 1'b0;
        chk("clear_priority", alert_lvl, 0);
        chk("clear_blink", blink_en, 0);

        // Ack held through reset is not an edge
        ack = 1'b1; rst = 1'b1; run(2);
        rst = 1'b0; state = 3'd5; cyc();
        chk("held_ack_warn", alert_lvl, 1);
        run(5);
        chk("held_ack_still_warn", alert_lvl, 1);
        ack = 1'b0; cyc(); ack = 1'b1; cyc();
        chk("repress_snooze", alert_lvl, 3);
        ack = 1'b0; cyc();

        // Maximum level while snoozed
        state = 3'd7; cyc();
`ifdef CRITICAL_BYPASS_EN
        chk("crit_urgent", alert_lvl, 2);
`else
        chk("crit_plain", alert_lvl, 3);
`endif
        ack = 1'b1; cyc(); ack = 1'b0; cyc();
        state = 3'd5; run(3);
        state = 3'd0; cyc();
        chk("crit_clear", alert_lvl, 0);

        // Random soak against the model
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 49) == 0)
                state = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 3))
                                                    : 3'($urandom_range(4, 7));
            if ($urandom_range(0, 59) == 0) ack = ~ack;
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
